// File: rtl/snn_ff_pkg.sv
// Shared definitions for the SNN feed-forward blocks.
//   pre_ctrl_state_e : state encoding of the presynaptic spike-count controller
//   clog2            : ceiling log2 used to size address / index fields (minimum 1)
package snn_ff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_WR    = 2'd2,
        ST_SWEEP = 2'd3
    } pre_ctrl_state_e;

    // Ceiling log2, never below 1 so single-entry fields still get one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pre_neuron_ctrl.sv
// Presynaptic spike-count controller.
// Turns input spikes into read-modify-write cycles on the spike-count SRAM,
// tracks the time step inside a reference window and, at the end of each
// window, sweeps every count back to zero.
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   spk_valid/spk_addr/spk_ready     spike request handshake
//   step_done                        end-of-time-step strobe
//   sram_cs/we/addr/wdata, rdata     single-port SRAM request / read data
//   neuron_event(_pulse), time_ref_event, current_time_step,
//   pre_spike_cnt, pre_spike_cnt_next  interface to the pre-neuron update logic
//   busy, sweep_done, step_err       status
module pre_neuron_ctrl
    import snn_ff_pkg::*;
#(
    parameter int unsigned N                        = 256,
    parameter int unsigned PRE_NEUR_SPIKE_CNT_WIDTH = 8,
    parameter int unsigned TIME_STEP                = 8,
    localparam int unsigned AW = clog2(N),
    localparam int unsigned TW = clog2(TIME_STEP),
    localparam int unsigned CW = PRE_NEUR_SPIKE_CNT_WIDTH
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          spk_valid,
    input  logic [AW-1:0] spk_addr,
    output logic          spk_ready,
    input  logic          step_done,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [CW-1:0] sram_wdata,
    input  logic [CW-1:0] sram_rdata,
    output logic          neuron_event,
    output logic          neuron_event_pulse,
    output logic          time_ref_event,
    output logic [TW-1:0] current_time_step,
    output logic [CW-1:0] pre_spike_cnt,
    input  logic [CW-1:0] pre_spike_cnt_next,
    output logic          busy,
    output logic          sweep_done,
    output logic          step_err
);

    pre_ctrl_state_e state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   sweep_q, sweep_d;
    logic [TW-1:0]   ts_q, ts_d;
    logic            pend_q, pend_d;
    logic            err_q, err_d;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sweep_q <= '0;
            ts_q    <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sweep_q <= sweep_d;
            ts_q    <= ts_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; a step strobe is serviced in the same IDLE cycle it
    // arrives, so it always wins over a simultaneous spike.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sweep_d = sweep_q;
        ts_d    = ts_q;
        pend_d  = pend_q | step_done;
        err_d   = err_q | (step_done & pend_q);
        case (state_q)
            ST_IDLE: begin
                if (pend_q || step_done) begin
                    if (ts_q < TW'(TIME_STEP - 1)) begin
                        ts_d   = ts_q + TW'(1);
                        pend_d = 1'b0;
                    end else begin
                        state_d = ST_SWEEP;
                        sweep_d = '0;
                    end
                end else if (spk_valid) begin
                    state_d = ST_RD;
                    addr_d  = spk_addr;
                end
            end
            ST_RD: state_d = ST_WR;
            ST_WR: state_d = ST_IDLE;
            ST_SWEEP: begin
                // pend stays set for the whole sweep, so extra strobes only flag step_err
                if (sweep_q == AW'(N - 1)) begin
                    state_d = ST_IDLE;
                    ts_d    = '0;
                    pend_d  = 1'b0;
                end else begin
                    sweep_d = sweep_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; everything is forced low in a reset cycle so no write can issue.
    always_comb begin
        spk_ready          = 1'b0;
        sram_cs            = 1'b0;
        sram_we            = 1'b0;
        sram_addr          = '0;
        sram_wdata         = '0;
        neuron_event       = 1'b0;
        neuron_event_pulse = 1'b0;
        time_ref_event     = 1'b0;
        sweep_done         = 1'b0;
        busy               = 1'b0;
        if (!RST) begin
            busy = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: spk_ready = ~pend_q & ~step_done;
                ST_RD: begin
                    sram_cs      = 1'b1;
                    sram_addr    = addr_q;
                    neuron_event = 1'b1;
                end
                ST_WR: begin
                    sram_cs            = 1'b1;
                    sram_we            = 1'b1;
                    sram_addr          = addr_q;
                    sram_wdata         = pre_spike_cnt_next;
                    neuron_event       = 1'b1;
                    neuron_event_pulse = 1'b1;
                end
                ST_SWEEP: begin
                    sram_cs        = 1'b1;
                    sram_we        = 1'b1;
                    sram_addr      = sweep_q;
                    sram_wdata     = pre_spike_cnt_next;
                    time_ref_event = 1'b1;
                    sweep_done     = (sweep_q == AW'(N - 1));
                end
                default: busy = 1'b0;
            endcase
        end
    end

    assign pre_spike_cnt     = RST ? '0 : sram_rdata;
    assign current_time_step = RST ? '0 : ts_q;
    assign step_err          = RST ? 1'b0 : err_q;

endmodule

// File: tb/tb_pre_neuron_ctrl.sv
// Self-checking bench for pre_neuron_ctrl: SRAM and pre-neuron models around
// the DUT, a transaction-level reference model checked every cycle, directed
// scenarios pinned with literal values, then randomized traffic.
module tb_pre_neuron_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned T  = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned TW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          spk_valid = 1'b0;
    logic [AW-1:0] spk_addr = '0;
    logic          spk_ready;
    logic          step_done = 1'b0;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [CW-1:0] sram_wdata;
    logic [CW-1:0] sram_rdata;
    logic          neuron_event, neuron_event_pulse, time_ref_event;
    logic [TW-1:0] current_time_step;
    logic [CW-1:0] pre_spike_cnt;
    logic [CW-1:0] pre_spike_cnt_next;
    logic          busy, sweep_done, step_err;
    logic          clr_mem = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int sd_seen = 0;

    pre_neuron_ctrl #(.N(N), .PRE_NEUR_SPIKE_CNT_WIDTH(CW), .TIME_STEP(T)) dut (
        .CLK(CLK), .RST(RST),
        .spk_valid(spk_valid), .spk_addr(spk_addr), .spk_ready(spk_ready),
        .step_done(step_done),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .neuron_event(neuron_event), .neuron_event_pulse(neuron_event_pulse),
        .time_ref_event(time_ref_event), .current_time_step(current_time_step),
        .pre_spike_cnt(pre_spike_cnt), .pre_spike_cnt_next(pre_spike_cnt_next),
        .busy(busy), .sweep_done(sweep_done), .step_err(step_err)
    );

    always #5 CLK = ~CLK;

    // Single-port SRAM, one-cycle read latency
    logic [CW-1:0] mem [N];
    always @(posedge CLK) begin
        if (clr_mem) begin
            for (int i = 0; i < int'(N); i++) mem[i] <= '0;
            sram_rdata <= '0;
        end else begin
            if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
            if (sram_cs && sram_we)  mem[sram_addr] <= sram_wdata;
        end
    end

    // Pre-neuron update: a spike adds the remaining steps of the window, a reference event clears
    always_comb begin
        pre_spike_cnt_next = '0;
        if (!time_ref_event)
            pre_spike_cnt_next = CW'(pre_spike_cnt + CW'(T) - CW'(current_time_step));
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: activity is idle(0), a spike transaction(1) or a sweep(2)
    int m_kind = 0, m_pos = 0, m_addr = 0, m_ts = 0;
    bit m_pend = 0, m_err = 0;
    int ref_mem [N];
    int e_ready, e_cs, e_we, e_addr, e_wd, e_ne, e_pulse, e_tref, e_sd, e_busy, e_ts, e_err;

    always @(negedge CLK) begin
        if (clr_mem) for (int i = 0; i < int'(N); i++) ref_mem[i] = 0;
        e_ready = 0; e_cs = 0; e_we = 0; e_addr = 0; e_wd = 0; e_ne = 0;
        e_pulse = 0; e_tref = 0; e_sd = 0; e_busy = 0; e_ts = 0; e_err = 0;
        if (!RST) begin
            e_ts = m_ts; e_err = int'(m_err);
            if (m_kind == 0) begin
                e_ready = int'(!m_pend && !step_done);
            end else if (m_kind == 1) begin
                e_busy = 1; e_cs = 1; e_addr = m_addr; e_ne = 1;
                if (m_pos == 1) begin
                    e_we = 1; e_pulse = 1;
                    e_wd = (ref_mem[m_addr] + int'(T) - m_ts) % 256;
                    chk("pre_spike_cnt", int'(pre_spike_cnt), ref_mem[m_addr]);
                end
            end else begin
                e_busy = 1; e_cs = 1; e_we = 1; e_addr = m_pos; e_tref = 1;
                e_sd = int'(m_pos == int'(N) - 1);
            end
        end
        chk("spk_ready", int'(spk_ready), e_ready);
        chk("sram_cs", int'(sram_cs), e_cs);
        chk("sram_we", int'(sram_we), e_we);
        chk("sram_addr", int'(sram_addr), e_addr);
        chk("sram_wdata", int'(sram_wdata), e_wd);
        chk("neuron_event", int'(neuron_event), e_ne);
        chk("neuron_event_pulse", int'(neuron_event_pulse), e_pulse);
        chk("time_ref_event", int'(time_ref_event), e_tref);
        chk("sweep_done", int'(sweep_done), e_sd);
        chk("busy", int'(busy), e_busy);
        chk("current_time_step", int'(current_time_step), e_ts);
        chk("step_err", int'(step_err), e_err);
        if (!RST && sweep_done) sd_seen++;

        if (RST) begin
            m_kind = 0; m_ts = 0; m_pend = 0; m_err = 0;
        end else begin
            if (step_done && m_pend) m_err = 1;
            if (m_kind == 0) begin
                if (m_pend || step_done) begin
                    if (m_ts < int'(T) - 1) begin
                        m_ts++; m_pend = 0;
                    end else begin
                        m_kind = 2; m_pos = 0; m_pend = 1;
                    end
                end else if (spk_valid) begin
                    m_kind = 1; m_pos = 0; m_addr = int'(spk_addr);
                end
            end else if (m_kind == 1) begin
                m_pend = m_pend | step_done;
                if (m_pos == 0) m_pos = 1;
                else begin
                    ref_mem[m_addr] = e_wd;
                    m_kind = 0;
                end
            end else begin
                ref_mem[m_pos] = 0;
                if (m_pos == int'(N) - 1) begin
                    m_kind = 0; m_ts = 0; m_pend = 0;
                end else m_pos++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; tick(2);
        RST = 1'b0;
    endtask

    task automatic step_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            step_done = 1'b1; tick();
            step_done = 1'b0; tick();
        end
    endtask

    int sd_base;
    int found;

    initial begin
        clr_mem = 1'b1;
        RST = 1'b1;
        tick(3);
        clr_mem = 1'b0;
        RST = 1'b0;
        #2 chk("reset_ts", int'(current_time_step), 0);
        chk("reset_ready", int'(spk_ready), 1);

        // Spike at addr 5 in time step 2: 0 + (8-2) = 6
        step_pulses(2);
        #2 chk("ts_after_two_steps", int'(current_time_step), 2);
        spk_valid = 1'b1; spk_addr = 3'd5; tick();
        spk_valid = 1'b0; tick(4);
        chk("model_mem5", ref_mem[5], 6);
        chk("sram_mem5", int'(mem[5]), 6);

        // Step and spike together: step first (0->1), spike next cycle: 0 + 7
        do_reset();
        step_done = 1'b1; spk_valid = 1'b1; spk_addr = 3'd3; tick();
        step_done = 1'b0; tick();
        spk_valid = 1'b0; tick(4);
        chk("ts_after_step_spike", int'(current_time_step), 1);
        chk("sram_mem3", int'(mem[3]), 7);

        // Two strobes during a spike transaction: one increment, sticky error
        spk_valid = 1'b1; spk_addr = 3'd1; tick();
        spk_valid = 1'b0; step_done = 1'b1; tick(2);
        step_done = 1'b0; tick(4);
        chk("step_err_set", int'(step_err), 1);
        chk("ts_single_incr", int'(current_time_step), 2);

        // Back-to-back spikes to addr 7 at step 0: 8 then 16
        do_reset();
        #2 chk("step_err_cleared", int'(step_err), 0);
        spk_valid = 1'b1; spk_addr = 3'd7; tick(4);
        spk_valid = 1'b0; tick(4);
        chk("sram_mem7", int'(mem[7]), 16);

        // Full window: eight steps then a sweep of every address
        sd_base = sd_seen;
        step_pulses(8);
        tick(int'(N) + 3);
        chk("sweep_done_count", sd_seen - sd_base, 1);
        chk("ts_after_sweep", int'(current_time_step), 0);
        chk("sram_mem7_swept", int'(mem[7]), 0);
        chk("sram_mem3_swept", int'(mem[3]), 0);

        // Reset in the middle of a sweep: addr 2 is never written
        spk_valid = 1'b1; spk_addr = 3'd2; tick();
        spk_valid = 1'b0; tick(4);
        step_pulses(8);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (sram_cs && time_ref_event && sram_addr == 3'd2) found = 1;
            else tick();
        end
        chk("wait_sweep_addr2", found, 1);
        RST = 1'b1;
        #2 chk("rst_sweep_cs", int'(sram_cs), 0);
        tick();
        RST = 1'b0;
        #2 chk("rst_sweep_busy", int'(busy), 0);
        chk("rst_sweep_ts", int'(current_time_step), 0);
        tick(3);
        chk("sram_mem2_kept", int'(mem[2]), 8);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            RST       = ($urandom_range(63) == 0);
            spk_valid = $urandom_range(1);
            spk_addr  = AW'($urandom_range(N - 1));
            step_done = ($urandom_range(7) == 0);
            tick();
        end
        RST = 1'b0; spk_valid = 1'b0; step_done = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
